// File: rtl/memory_wrapper_sdp.sv
`default_nettype none
// ============================================================================
// Module      : memory_wrapper_sdp
// Description : Simple-dual-port synchronous RAM with byte write enables,
//               1/2-cycle read latency, read-during-write policy and a
//               post-reset hardware clear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_wrapper_sdp #(
  parameter int  ADDR_WIDTH     = 6,
  parameter int  DATA_WIDTH     = 32,
  parameter int  OUT_REG        = 0,
  parameter int  RDW_MODE       = 0,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cen,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_cen,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_vld1_q, rd_vld1_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;

  // Clear walks every word once, then parks in IDLE until the next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign wr_en     = (state_q == ST_IDLE) && !wr_cen;
  assign rd_en     = (state_q == ST_IDLE) && !rd_cen;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // New-data mode forwards the enabled write bytes onto a colliding read.
  if (RDW_MODE != 0) begin : g_rdw_new
    always_comb begin
      rd_word = mem[raddr];
      if (wr_en && (waddr == raddr)) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr_be[i]) begin
            rd_word[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end
    end
  end else begin : g_rdw_old
    assign rd_word = mem[raddr];
  end

  always_comb begin
    rd_vld1_d  = rd_en;
    rd_data1_d = rd_en ? rd_word : rd_data1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld1_q  <= 1'b0;
      rd_data1_q <= '0;
    end else begin
      rd_vld1_q  <= rd_vld1_d;
      rd_data1_q <= rd_data1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_vld2_q, rd_vld2_d;
    logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

    always_comb begin
      rd_vld2_d  = rd_vld1_q;
      rd_data2_d = rd_vld1_q ? rd_data1_q : rd_data2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_vld2_q  <= 1'b0;
        rd_data2_q <= '0;
      end else begin
        rd_vld2_q  <= rd_vld2_d;
        rd_data2_q <= rd_data2_d;
      end
    end

    assign rdata  = rd_data2_q;
    assign rvalid = rd_vld2_q;
  end else begin : g_no_out_reg
    assign rdata  = rd_data1_q;
    assign rvalid = rd_vld1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_wrapper_sdp.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_wrapper_sdp
// Description : Scoreboard bench driving two RAM configurations in lockstep:
//               dut0 (latency 1, old-data RDW), dut1 (latency 2, new-data RDW).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_wrapper_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_cen;
  logic [3:0]  wr_be;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        rd_cen;
  logic [3:0]  raddr;
  logic [31:0] rd0, rd1;
  logic        rv0, rv1;
  logic        busy0, busy1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q [2][$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        mv;
  logic [31:0] md;
  exp_t        me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_wrapper_sdp #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst), .wr_cen(wr_cen), .wr_be(wr_be), .waddr(waddr),
    .wdata(wdata), .rd_cen(rd_cen), .raddr(raddr), .rdata(rd0),
    .rvalid(rv0), .init_busy(busy0)
  );

  memory_wrapper_sdp #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_cen(wr_cen), .wr_be(wr_be), .waddr(waddr),
    .wdata(wdata), .rd_cen(rd_cen), .raddr(raddr), .rdata(rd1),
    .rvalid(rv1), .init_busy(busy1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a DUT raises rvalid.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mv = (k == 0) ? rv0 : rv1;
      md = (k == 0) ? rd0 : rd1;
      if (mv) begin
        if (q[k].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rvalid%0d unexpected: actual 1 required 0 (rdata %h cycle %0d)", k, md, cyc);
        end else begin
          me = q[k].pop_front();
          chk($sformatf("rdata%0d", k), md, me.d);
          chk($sformatf("rvalid%0d cycle", k), cyc, me.due);
        end
      end else if (q[k].size() > 0 && q[k][0].due <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL rvalid%0d missing: actual 0 required 1 at cycle %0d", k, q[k][0].due);
        void'(q[k].pop_front());
      end
    end
  end

  // One cycle of access; expectations are queued at issue time.
  task automatic acc(input bit do_wr, input logic [3:0] wa, input logic [31:0] d,
                     input logic [3:0] be, input bit do_rd, input logic [3:0] ra,
                     input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    wr_cen = !do_wr;
    waddr  = wa;
    wdata  = d;
    wr_be  = be;
    rd_cen = !do_rd;
    raddr  = ra;
    if (do_rd) begin
      e.d = e0; e.due = cyc + 1; q[0].push_back(e);
      e.d = e1; e.due = cyc + 2; q[1].push_back(e);
    end
    @(negedge clk);
    wr_cen = 1'b1;
    rd_cen = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    acc(1'b1, a, d, be, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    acc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, e0, e1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Releases reset and measures how long init_busy stays high.
  task automatic release_and_count(input string tag);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      c0 += int'(busy0);
      c1 += int'(busy1);
      @(negedge clk);
    end
    chk({tag, " busy cycles dut0"}, c0, 16);
    chk({tag, " busy cycles dut1"}, c1, 16);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    wr_cen = 1'b1;
    rd_cen = 1'b1;
    wr_be  = 4'h0;
    waddr  = 4'd0;
    wdata  = 32'd0;
    raddr  = 4'd0;
    idle(3);
    chk("reset rdata0",  rd0,   32'd0);
    chk("reset rvalid0", rv0,   32'd0);
    chk("reset busy0",   busy0, 32'd1);
    chk("reset rdata1",  rd1,   32'd0);
    chk("reset rvalid1", rv1,   32'd0);
    chk("reset busy1",   busy1, 32'd1);

    // A read in the release cycle must be dropped; the monitor flags any rvalid.
    rd_cen = 1'b0;
    raddr  = 4'd3;
    fork
      begin @(negedge clk); rd_cen = 1'b1; end
    join_none
    release_and_count("clear");

    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, 32'd0);
    idle(3);

    wr(4'd5, 32'hDEADBEEF, 4'b1111);
    wr(4'd5, 32'h11223344, 4'b0101);
    rd(4'd5, 32'hDE22BE44, 32'hDE22BE44);
    idle(3);

    for (int a = 0; a < 8; a++) wr(4'(a), 32'(a * 3), 4'b1111);
    for (int a = 0; a < 8; a++) rd(4'(a), 32'(a * 3), 32'(a * 3));
    idle(3);

    wr(4'd9, 32'hAAAAAAAA, 4'b1111);
    acc(1'b1, 4'd9, 32'h55555555, 4'b0011, 1'b1, 4'd9, 32'hAAAAAAAA, 32'hAAAA5555);
    rd(4'd9, 32'hAAAA5555, 32'hAAAA5555);
    acc(1'b1, 4'd10, 32'h12345678, 4'b1111, 1'b1, 4'd9, 32'hAAAA5555, 32'hAAAA5555);
    wr(4'd10, 32'hFFFFFFFF, 4'b0000);
    rd(4'd10, 32'h12345678, 32'h12345678);
    idle(6);
    chk("hold rdata0", rd0, 32'h12345678);
    chk("hold rdata1", rd1, 32'h12345678);

    // Reset in the middle of the clear: clear restarts and runs the full length.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(7);
    rst = 1'b1;
    @(negedge clk);
    chk("midclear busy0", busy0, 32'd1);
    chk("midclear busy1", busy1, 32'd1);
    @(negedge clk);
    release_and_count("reclear");
    rd(4'd5, 32'd0, 32'd0);
    rd(4'd9, 32'd0, 32'd0);
    rd(4'd15, 32'd0, 32'd0);
    idle(3);

    // Reset while a latency-2 read is in flight.
    wr(4'd3, 32'hCAFEF00D, 4'b1111);
    rd(4'd3, 32'hCAFEF00D, 32'hCAFEF00D);
    idle(3);
    begin
      exp_t e;
      rd_cen = 1'b0;
      raddr  = 4'd3;
      e.d    = 32'hCAFEF00D;
      e.due  = cyc + 1;
      q[0].push_back(e);
      @(negedge clk);
      rd_cen = 1'b1;
      #2 rst = 1'b1;
    end
    idle(4);
    chk("flush rdata1",  rd1, 32'd0);
    chk("flush rvalid1", rv1, 32'd0);
    chk("flush rdata0",  rd0, 32'd0);
    rst = 1'b0;
    idle(20);
    chk("scoreboard0 empty", q[0].size(), 32'd0);
    chk("scoreboard1 empty", q[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
